// File: rtl/sar_control_if.sv
// Handshake and data signals between the SAR controller, the sample/hold,
// the DAC/comparator and the downstream consumer.
interface sar_control_if #(
    parameter int unsigned NBITS = 10
);
    logic             start;
    logic             continuous;
    logic             comp_in;
    logic             sample;
    logic [NBITS-1:0] dac_code;
    logic [NBITS-1:0] data_out;
    logic             data_valid;
    logic             busy;

    modport master (
        output start, continuous, comp_in,
        input  sample, dac_code, data_out, data_valid, busy
    );

    modport slave (
        input  start, continuous, comp_in,
        output sample, dac_code, data_out, data_valid, busy
    );
endinterface

// File: rtl/sar_control.sv
// Successive-approximation controller: samples, resolves NBITS bits MSB-first
// against the comparator and presents the result with a one-cycle valid strobe.
module sar_control #(
    parameter int unsigned NBITS         = 10,
    parameter int unsigned SAMPLE_CYCLES = 4,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    sar_control_if.slave  bus
);
    localparam int unsigned BW = (NBITS > 1) ? $clog2(NBITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SAMPLE,
        S_CONVERT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             sample_q, sample_d;
    logic [NBITS-1:0] dac_q, dac_d;
    logic [NBITS-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            sample_q <= 1'b0;
            dac_q    <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sample_q <= sample_d;
            dac_q    <= dac_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        sample_d = sample_q;
        dac_d    = dac_q;
        dout_d   = dout_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_SAMPLE;
                    sample_d = 1'b1;
                    busy_d   = 1'b1;
                    dac_d    = '0;
                    cnt_d    = 8'(SAMPLE_CYCLES - 1);
                end
            end

            S_SAMPLE: begin
                if (cnt_q == '0) begin
                    state_d            = S_CONVERT;
                    sample_d           = 1'b0;
                    bit_d              = BW'(NBITS - 1);
                    dac_d              = '0;
                    dac_d[NBITS-1]     = 1'b1;
                    cnt_d              = 8'(SETTLE_CYCLES);
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            S_CONVERT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    // Decision edge: keep/clear the bit under trial, then either
                    // raise the next trial bit or publish the finished code.
                    dac_d[bit_q] = bus.comp_in;
                    if (bit_q != '0) begin
                        dac_d[bit_q - BW'(1)] = 1'b1;
                        bit_d                 = bit_q - BW'(1);
                        cnt_d                 = 8'(SETTLE_CYCLES);
                    end else begin
                        dout_d  = dac_d;
                        valid_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                dac_d = '0;
                bit_d = '0;
                if (bus.continuous) begin
                    state_d  = S_SAMPLE;
                    sample_d = 1'b1;
                    cnt_d    = 8'(SAMPLE_CYCLES - 1);
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign bus.sample     = sample_q;
    assign bus.dac_code   = dac_q;
    assign bus.data_out   = dout_q;
    assign bus.data_valid = valid_q;
    assign bus.busy       = busy_q;
endmodule
